gp0_axil_regfile: RTL

GP0_AXIL_REGFILE -- requirements
Module: gp0_axil_regfile

---
 rtl/gp0_regs_pkg.sv | 33 +++
 rtl/gp0_edge_det.sv | 27 ++
 rtl/gp0_axil_regfile.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gp0_regs_pkg.sv
// Shared definitions for the GP0 AXI4-Lite register file: register map,
// response codes, FSM state types and the byte-strobe merge helper.
package gp0_regs_pkg;

    // Register map expressed as word indices (byte offset / 4).
    localparam logic [31:0] REG_ID       = 32'd0;  // 0x00
    localparam logic [31:0] REG_SCRATCH  = 32'd1;  // 0x04
    localparam logic [31:0] REG_CTRL     = 32'd2;  // 0x08
    localparam logic [31:0] REG_STATUS   = 32'd3;  // 0x0C
    localparam logic [31:0] REG_CYCLES   = 32'd4;  // 0x10
    localparam logic [31:0] REG_IRQ_PEND = 32'd5;  // 0x14
    localparam logic [31:0] REG_IRQ_EN   = 32'd6;  // 0x18
    localparam logic [31:0] REG_LAST     = REG_IRQ_EN;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Replace only the bytes of old_val whose strobe bit is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/gp0_edge_det.sv
// Registered rising-edge detector: o_rise pulses for one cycle, one cycle
// after the clock edge at which i_sig is first seen high.
module gp0_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    // Keep one sample of history and register the compare against it.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/gp0_axil_regfile.sv
// AXI4-Lite slave register file for the GP0 port: ID, scratch, control,
// sampled status, free-running cycle counter and a one-bit interrupt block.
module gp0_axil_regfile
    import gp0_regs_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h5A10_0001,
    parameter int          ADDR_W   = 6
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic [31:0]       ctrl_o,
    input  logic [31:0]       status_i,
    input  logic              irq_i,
    output logic              irq_o
);

    wr_state_t         r_wr_state, w_wr_next;
    rd_state_t         r_rd_state, w_rd_next;
    logic              r_out_of_rst;
    logic              r_aw_held, r_w_held;
    logic [ADDR_W-3:0] r_aw_word;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [1:0]        r_bresp, r_rresp;
    logic [31:0]       r_rdata;
    logic [31:0]       r_scratch, r_ctrl, r_status, r_cycles;
    logic              r_irq_pend, r_irq_en, r_irq;
    logic              w_awready, w_wready, w_arready, w_bvalid, w_rvalid;
    logic              w_wr_commit, w_irq_rise, w_pend_clear;
    logic [31:0]       w_wr_idx, w_rd_idx, w_rd_data;
    logic [1:0]        w_rd_resp;
    logic              w_unused;

    // Address bits [1:0] select bytes within a word and are ignored.
    assign w_unused = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign w_wr_idx = 32'(r_aw_word);
    assign w_rd_idx = 32'(S_AXI_ARADDR[ADDR_W-1:2]);

    gp0_edge_det u_irq_edge (
        .i_clk  (S_AXI_ACLK),
        .i_rst  (S_AXI_ARESET),
        .i_sig  (irq_i),
        .o_rise (w_irq_rise)
    );

    // Holds the ready outputs low while in reset and releases them one cycle later.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) r_out_of_rst <= 1'b0;
        else              r_out_of_rst <= 1'b1;
    end

    // FSM state registers for both channels.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    // Write FSM: commit once address and data are both held, then respond.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_wr_next   = r_wr_state;
        w_wr_commit = 1'b0;
        w_bvalid    = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (r_aw_held && r_w_held) begin
                    w_wr_commit = 1'b1;
                    w_wr_next   = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (S_AXI_BREADY) w_wr_next = W_IDLE;
            end
            default: w_wr_next = W_IDLE;
        endcase
        w_awready = r_out_of_rst && !r_aw_held && (r_wr_state == W_IDLE);
        w_wready  = r_out_of_rst && !r_w_held  && (r_wr_state == W_IDLE);
    end

    // Read FSM: one outstanding read, data captured at the AR handshake.
    always_comb begin
        w_rd_next = r_rd_state;
        w_rvalid  = 1'b0;
        case (r_rd_state)
            R_IDLE: if (S_AXI_ARVALID && w_arready) w_rd_next = R_DATA;
            R_DATA: begin
                w_rvalid = 1'b1;
                if (S_AXI_RREADY) w_rd_next = R_IDLE;
            end
            default: w_rd_next = R_IDLE;
        endcase
        w_arready = r_out_of_rst && (r_rd_state == R_IDLE);
    end

    // Flags marking a latched address / data beat; reset drops any half-accepted write.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (S_AXI_AWVALID && w_awready) r_aw_held <= 1'b1;
            else if (w_wr_commit)           r_aw_held <= 1'b0;
            if (S_AXI_WVALID && w_wready)   r_w_held  <= 1'b1;
            else if (w_wr_commit)           r_w_held  <= 1'b0;
        end
    end

    // Address/data payload, only ever consumed while its held flag is set.
    always_ff @(posedge S_AXI_ACLK) begin
        // NOTE: payload flops carry no reset; the held flags qualify them, so reset would only add fan-out.
        if (S_AXI_AWVALID && w_awready) r_aw_word <= S_AXI_AWADDR[ADDR_W-1:2];
        if (S_AXI_WVALID && w_wready) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
        end
    end

    // Write response code, stable for the whole W_RESP phase.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET)     r_bresp <= RESP_OKAY;
        else if (w_wr_commit) r_bresp <= (w_wr_idx <= REG_LAST) ? RESP_OKAY : RESP_DECERR;
    end

    // Byte-gated updates of the read/write registers; RO and unmapped writes fall through.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_scratch <= '0;
            r_ctrl    <= '0;
            r_irq_en  <= 1'b0;
        end else if (w_wr_commit) begin
            case (w_wr_idx)
                REG_SCRATCH: r_scratch <= strb_merge(r_scratch, r_wdata, r_wstrb);
                REG_CTRL:    r_ctrl    <= strb_merge(r_ctrl, r_wdata, r_wstrb);
                REG_IRQ_EN:  if (r_wstrb[0]) r_irq_en <= r_wdata[0];
                default: ;
            endcase
        end
    end

    assign w_pend_clear = w_wr_commit && (w_wr_idx == REG_IRQ_PEND) && r_wstrb[0] && r_wdata[0];

    // Interrupt pending (set beats clear), registered interrupt output, status sample and cycle counter.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_irq_pend <= 1'b0;
            r_irq      <= 1'b0;
            r_status   <= '0;
            r_cycles   <= '0;
        end else begin
            if (w_irq_rise)        r_irq_pend <= 1'b1;
            else if (w_pend_clear) r_irq_pend <= 1'b0;
            r_irq    <= r_irq_pend & r_irq_en;
            r_status <= status_i;
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // Read mux on the incoming address; sees pre-write register values.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_rd_idx)
            REG_ID:       w_rd_data = ID_VALUE;
            REG_SCRATCH:  w_rd_data = r_scratch;
            REG_CTRL:     w_rd_data = r_ctrl;
            REG_STATUS:   w_rd_data = r_status;
            REG_CYCLES:   w_rd_data = r_cycles;
            REG_IRQ_PEND: w_rd_data = {31'd0, r_irq_pend};
            REG_IRQ_EN:   w_rd_data = {31'd0, r_irq_en};
            default:      w_rd_resp = RESP_DECERR;
        endcase
    end

    // Capture read data at the AR handshake and hold it until RREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (S_AXI_ARVALID && w_arready) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = w_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign ctrl_o        = r_ctrl;
    assign irq_o         = r_irq;

endmodule
